// File: rtl/stall_mem_responder_pkg.sv
// stall_mem_responder_pkg: shared encodings for the multi-cycle data memory.
// Holds FSM states, latched op codes and the latency legality check.
package stall_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_ERR = 2'b10
  } op_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  function automatic bit lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/resp_mem_array.sv
// resp_mem_array: word storage with sync write and a load-enabled read reg.
// Ports: clk, rst (async low, read reg only), we/waddr/wdata, re/raddr, rdata.
module resp_mem_array
  import stall_mem_responder_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stall_mem_responder.sv
// stall_mem_responder: fixed-latency word memory with Stall/Done/Err handshake.
// Ports: clk, rst (async low), Rd, Wr, Addr, DataIn -> DataOut, Stall, Done, Err.
module stall_mem_responder
  import stall_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Stall,
  output logic              Done,
  output logic              Err
);

  if (!lat_legal(LATENCY)) begin : g_bad_lat
    $error("stall_mem_responder: LATENCY must be 1..15");
  end

  if (ADDR_W <= DEPTH_LOG2 + 1) begin : g_bad_aw
    $error("stall_mem_responder: ADDR_W too small for DEPTH_LOG2");
  end

  localparam bit LAT1 = (LATENCY == 1);

  // Counter holds remaining BUSY cycles minus one.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  op_t op_q;
  op_t op_in;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_in;

  logic req;
  logic accept;
  logic bad;
  logic wr_ok;
  logic rd_ok;

  logic                  mem_we;
  logic                  mem_re;
  logic [DEPTH_LOG2-1:0] mem_raddr;
  logic [DATA_W-1:0]     mem_rdata;

  // Upper address bits alias onto the array.
  logic unused_hi;
  assign unused_hi = ^Addr[ADDR_W-1:DEPTH_LOG2+1];

  assign req    = Rd | Wr;
  assign idx_in = Addr[DEPTH_LOG2:1];
  assign bad    = (Rd & Wr) | Addr[0];
  assign wr_ok  = Wr & ~bad;
  assign rd_ok  = Rd & ~bad;

  assign accept = req & ((state == IDLE) | (state == DONE));

  always_comb begin
    op_in = OP_RD;
    unique case (1'b1)
      bad:     op_in = OP_ERR;
      wr_ok:   op_in = OP_WR;
      rd_ok:   op_in = OP_RD;
      default: op_in = OP_RD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_RD;
      idx_q <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      idx_q <= idx_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (req) begin
          state_n = LAT1 ? DONE : BUSY;
          cnt_n   = CNT_INIT;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Stall   = 1'b0;
    Done    = 1'b0;
    Err     = 1'b0;
    DataOut = '0;
    unique case (state)
      IDLE: Stall = req;
      BUSY: Stall = 1'b1;
      DONE: begin
        Stall = req;
        Done  = 1'b1;
        Err   = (op_q == OP_ERR);
        if (op_q == OP_RD) begin
          DataOut = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Writes commit at acceptance; reads load on the edge entering DONE.
  assign mem_we = accept & (op_in == OP_WR);

  assign mem_re =
      ((state == BUSY) & (cnt == '0) & (op_q == OP_RD))
    | (LAT1 & accept & (op_in == OP_RD));

  assign mem_raddr = (state == BUSY) ? idx_q : idx_in;

  resp_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (idx_in),
    .wdata (DataIn),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_stall_mem_responder.sv
// tb_stall_mem_responder: random + directed bench against a timing model.
// Three instances cover LATENCY 2, 1 and 15.
module tb_stall_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        rd    [3];
  logic        wr    [3];
  logic [15:0] addr  [3];
  logic [15:0] din   [3];
  logic [15:0] dout  [3];
  logic        stall [3];
  logic        done  [3];
  logic        err   [3];

  stall_mem_responder #(.LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .Rd(rd[0]), .Wr(wr[0]),
    .Addr(addr[0]), .DataIn(din[0]), .DataOut(dout[0]),
    .Stall(stall[0]), .Done(done[0]), .Err(err[0])
  );

  stall_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .Rd(rd[1]), .Wr(wr[1]),
    .Addr(addr[1]), .DataIn(din[1]), .DataOut(dout[1]),
    .Stall(stall[1]), .Done(done[1]), .Err(err[1])
  );

  stall_mem_responder #(.LATENCY(15)) u_dut2 (
    .clk(clk), .rst(rst), .Rd(rd[2]), .Wr(wr[2]),
    .Addr(addr[2]), .DataIn(din[2]), .DataOut(dout[2]),
    .Stall(stall[2]), .Done(done[2]), .Err(err[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Reference model: word memory per instance plus one pending result.
  logic [15:0] mmem   [3][1024];
  bit          mknown [3][1024];
  bit          infl   [3];
  int          due    [3];
  bit          p_err  [3];
  bit          p_chk  [3];
  logic [15:0] p_data [3];

  int cyc;
  int n_chk;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // One clock cycle on instance k with the given request inputs.
  task automatic cycle(input int k, input bit r, input bit w,
                       input logic [15:0] a, input logic [15:0] d);
    bit busy;
    bit req;
    bit fin;
    int idx;
    rd[k] = r;
    wr[k] = w;
    addr[k] = a;
    din[k] = d;
    @(negedge clk);
    busy = infl[k] && (cyc < due[k]);
    fin  = infl[k] && (cyc == due[k]);
    req  = r | w;
    chk("stall", stall[k], busy | req);
    chk("done", done[k], fin);
    if (fin) begin
      chk("err", err[k], p_err[k]);
      if (p_chk[k]) chk("data", dout[k], p_data[k]);
    end else begin
      chk("err_idle", err[k], 1'b0);
      chk("dout_idle", dout[k], 16'h0);
    end
    if (!busy && req) begin
      idx = int'(a[10:1]);
      if ((r && w) || a[0]) begin
        p_err[k] = 1'b1;
        p_chk[k] = 1'b1;
        p_data[k] = 16'h0;
      end else if (w) begin
        mmem[k][idx] = d;
        mknown[k][idx] = 1'b1;
        p_err[k] = 1'b0;
        p_chk[k] = 1'b1;
        p_data[k] = 16'h0;
      end else begin
        p_err[k] = 1'b0;
        p_chk[k] = mknown[k][idx];
        p_data[k] = mmem[k][idx];
      end
      infl[k] = 1'b1;
      due[k] = cyc + lat_of(k);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    cycle(k, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Present a request, hold Rd/Wr while stalled, scramble Addr/DataIn
  // mid-stall; returns in the completion cycle without driving it.
  task automatic xfer(input int k, input bit r, input bit w,
                      input logic [15:0] a, input logic [15:0] d);
    cycle(k, r, w, a, d);
    for (int i = 0; i < 16; i++) begin
      if (!(infl[k] && cyc < due[k])) break;
      cycle(k, r, w, 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic rnd_xfer(input int k);
    int p;
    logic [15:0] a;
    bit r;
    bit w;
    p = $urandom_range(0, 99);
    a = 16'($urandom_range(0, 31) << 11)
      | 16'($urandom_range(0, 7) << 1);
    r = p < 45 || p >= 93;
    w = p >= 45 && p < 93;
    if (p >= 85 && p < 93) r = 1'b1;
    if (p >= 93) a[0] = 1'b1;
    xfer(k, r, w, a, 16'($urandom));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      addr[k] = 16'h0;
      din[k] = 16'h0;
      infl[k] = 1'b0;
      due[k] = 0;
      for (int j = 0; j < 1024; j++) mknown[k][j] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", stall[k], 1'b0);
      chk("rst_done", done[k], 1'b0);
      chk("rst_err", err[k], 1'b0);
      chk("rst_dout", dout[k], 16'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    xfer(0, 1'b0, 1'b1, 16'h0010, 16'h1234);
    idle(0);
    xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(0);

    xfer(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(0);

    xfer(0, 1'b1, 1'b0, 16'h0011, 16'h0);
    idle(0);

    xfer(0, 1'b0, 1'b1, 16'h0020, 16'h7777);
    idle(0);
    xfer(0, 1'b1, 1'b1, 16'h0020, 16'h1111);
    idle(0);
    xfer(0, 1'b1, 1'b0, 16'h0020, 16'h0);
    idle(0);

    xfer(0, 1'b0, 1'b1, 16'h0810, 16'hCAFE);
    idle(0);
    xfer(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(0);

    cycle(0, 1'b0, 1'b1, 16'h0030, 16'h5A5A);
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", stall[0], 1'b0);
    chk("mid_rst_done", done[0], 1'b0);
    chk("mid_rst_err", err[0], 1'b0);
    chk("mid_rst_dout", dout[0], 16'h0);
    infl[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    repeat (3) idle(0);
    xfer(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    idle(0);

    for (int k = 1; k < 3; k++) begin
      xfer(k, 1'b0, 1'b1, 16'h0040, 16'h4321);
      idle(k);
      xfer(k, 1'b1, 1'b0, 16'h0040, 16'h0);
      idle(k);
      xfer(k, 1'b0, 1'b1, 16'h0042, 16'h0F0F);
      xfer(k, 1'b1, 1'b0, 16'h0842, 16'h0);
      idle(k);
    end

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        xfer(k, 1'b0, 1'b1, 16'(j << 1), 16'($urandom));
        idle(k);
      end
      for (int t = 0; t < 60; t++) begin
        rnd_xfer(k);
        if ($urandom_range(0, 1) == 0) idle(k);
      end
      idle(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
